alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 190 +++++++++++++++++++
 tb/tb_alu_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle execute unit. Non-shift operations finish in one
// cycle. Shifts move one bit position per cycle instead of using a barrel
// shifter. Valid/ready handshakes are used on both the request and result sides.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Illegal
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_SLL   = 4'b0110;
  localparam logic [3:0] OP_SRL   = 4'b0111;
  localparam logic [3:0] OP_SRA   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_LUI   = 4'b1011;
  localparam logic [3:0] OP_AUIPC = 4'b1100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;

  logic [SHW-1:0]   shamt;
  logic             is_shift;
  logic             is_illegal;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] acc_step;

  // Single-cycle operations; unsupported codes and shift codes yield zero here.
  function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_SLT:   r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:  r = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_LUI:   r = b;
      OP_AUIPC: r = a + b;
      default:  r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign ALUResult = result_q;
  assign Zero      = zero_q;
  assign Illegal   = illegal_q;

  // Decode the incoming request: shift amount, shift class, illegal code, one-cycle result.
  always_comb begin
    shamt      = SrcB[SHW-1:0];
    is_shift   = (ALUControl == OP_SLL) || (ALUControl == OP_SRL) || (ALUControl == OP_SRA);
    is_illegal = (ALUControl == 4'b1010) || (ALUControl == 4'b1101) ||
                 (ALUControl == 4'b1110) || (ALUControl == 4'b1111);
    single_res = alu_single(ALUControl, SrcA, SrcB);
  end

  // One-bit shift step in the latched direction; sra keeps the sign bit, which equals the original MSB.
  always_comb begin
    case (op_q)
      OP_SLL:  acc_step = {acc_q[WIDTH-2:0], 1'b0};
      OP_SRL:  acc_step = {1'b0, acc_q[WIDTH-1:1]};
      OP_SRA:  acc_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      default: acc_step = acc_q;
    endcase
  end

  // Next-state and next-output logic of the IDLE/SHIFT/DONE controller.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_shift && (shamt != {SHW{1'b0}})) begin
            acc_d      = SrcA;
            cnt_d      = shamt;
            op_d       = ALUControl;
            state_d    = SHIFT;
            in_ready_d = 1'b0;
          end else begin
            result_d    = is_shift ? SrcA : single_res;
            zero_d      = is_shift ? (SrcA == {WIDTH{1'b0}}) : (single_res == {WIDTH{1'b0}});
            illegal_d   = is_illegal;
            state_d     = DONE;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        acc_d = acc_step;
        cnt_d = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
        if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) begin
          result_d    = acc_step;
          zero_d      = (acc_step == {WIDTH{1'b0}});
          illegal_d   = 1'b0;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; asynchronous reset discards any in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      acc_q       <= {WIDTH{1'b0}};
      cnt_q       <= {SHW{1'b0}};
      op_q        <= 4'b0000;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq with hand-computed expectations.
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        Illegal;

  int n_checks;
  int n_pass;

  alu_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .Illegal    (Illegal)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge, then measure latency to out_valid (no handshake).
  task automatic issue_op(input string tag, input logic [3:0] code, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat,
                          input logic [31:0] exp_res, input logic exp_ill);
    int lat;
    logic ir_low;
    @(negedge clk);
    check_eq({tag, " in_ready before"}, {31'd0, in_ready}, 32'd1);
    in_valid   = 1'b1;
    ALUControl = code;
    SrcA       = a;
    SrcB       = b;
    @(posedge clk);
    @(negedge clk);
    in_valid   = 1'b0;
    SrcA       = 32'hDEADBEEF;
    SrcB       = 32'h0000001F;
    ALUControl = 4'b0001;
    lat    = 1;
    ir_low = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) ir_low = 1'b0;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (in_ready) ir_low = 1'b0;
    check_eq({tag, " latency"}, lat, exp_lat);
    check_eq({tag, " in_ready low"}, {31'd0, ir_low}, 32'd1);
    check_eq({tag, " result"}, ALUResult, exp_res);
    check_eq({tag, " zero"}, {31'd0, Zero}, {31'd0, (exp_res == 32'd0)});
    check_eq({tag, " illegal"}, {31'd0, Illegal}, {31'd0, exp_ill});
  endtask

  // Complete the result handshake and confirm return to IDLE.
  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, " out_valid after hs"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, " in_ready after hs"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic held_ok;
    int   late_valid;
    n_checks   = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ALUControl = 4'b0000;
    SrcA       = 32'd0;
    SrcB       = 32'd0;

    // Reset values
    #12;
    check_eq("rst in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst result", ALUResult, 32'd0);
    check_eq("rst zero", {31'd0, Zero}, 32'd0);
    check_eq("rst illegal", {31'd0, Illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle operations
    issue_op("add wrap", 4'b0000, 32'hFFFFFFFF, 32'h00000001, 1, 32'h00000000, 1'b0);
    finish_op("add wrap");
    issue_op("sub", 4'b0001, 32'd5, 32'd7, 1, 32'hFFFFFFFE, 1'b0);
    finish_op("sub");
    issue_op("and", 4'b0010, 32'h0000F0F0, 32'h0000FF00, 1, 32'h0000F000, 1'b0);
    finish_op("and");
    issue_op("or", 4'b0011, 32'h0000F0F0, 32'h0000FF00, 1, 32'h0000FFF0, 1'b0);
    finish_op("or");
    issue_op("xor", 4'b0100, 32'h0000F0F0, 32'h0000FF00, 1, 32'h00000FF0, 1'b0);
    finish_op("xor");
    issue_op("slt", 4'b0101, 32'h80000000, 32'h00000001, 1, 32'h00000001, 1'b0);
    finish_op("slt");
    issue_op("sltu", 4'b1001, 32'h80000000, 32'h00000001, 1, 32'h00000000, 1'b0);
    finish_op("sltu");
    issue_op("lui", 4'b1011, 32'h0000ABCD, 32'h12345000, 1, 32'h12345000, 1'b0);
    finish_op("lui");
    issue_op("auipc", 4'b1100, 32'h00001000, 32'h00002000, 1, 32'h00003000, 1'b0);
    finish_op("auipc");
    issue_op("illegal 1010", 4'b1010, 32'h11111111, 32'h22222222, 1, 32'h00000000, 1'b1);
    finish_op("illegal 1010");

    // Shifts
    issue_op("sll 31", 4'b0110, 32'h00000001, 32'd31, 32, 32'h80000000, 1'b0);
    finish_op("sll 31");
    issue_op("sra 4", 4'b1000, 32'h80000000, 32'h00000024, 5, 32'hF8000000, 1'b0);
    finish_op("sra 4");
    issue_op("srl 4", 4'b0111, 32'h80000000, 32'h00000024, 5, 32'h08000000, 1'b0);
    finish_op("srl 4");
    issue_op("sll 0", 4'b0110, 32'h0000ABCD, 32'h00000020, 1, 32'h0000ABCD, 1'b0);
    finish_op("sll 0");

    // Backpressure on an illegal code; in_valid pulses during DONE must be ignored
    issue_op("illegal 1101", 4'b1101, 32'h00000003, 32'h00000004, 1, 32'h00000000, 1'b1);
    held_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid   = 1'b1;
      ALUControl = 4'b0000;
      SrcA       = 32'd9;
      SrcB       = 32'd9;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      if (!out_valid || in_ready || ALUResult != 32'd0 || !Zero || !Illegal) held_ok = 1'b0;
    end
    check_eq("bp held stable", {31'd0, held_ok}, 32'd1);
    check_eq("bp result", ALUResult, 32'd0);
    finish_op("bp release");
    check_eq("bp no accept result", ALUResult, 32'd0);
    check_eq("bp no accept illegal", {31'd0, Illegal}, 32'd1);

    // Reset in the middle of a shift
    @(negedge clk);
    in_valid   = 1'b1;
    ALUControl = 4'b0110;
    SrcA       = 32'h00000001;
    SrcB       = 32'd20;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check_eq("midrst in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("midrst result", ALUResult, 32'd0);
    check_eq("midrst zero", {31'd0, Zero}, 32'd0);
    check_eq("midrst illegal", {31'd0, Illegal}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue_op("post rst add", 4'b0000, 32'd2, 32'd3, 1, 32'd5, 1'b0);
    finish_op("post rst add");
    late_valid = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) late_valid++;
    end
    check_eq("no stale shift", late_valid, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
